// File: rtl/rgb_sched_pkg.sv
// rtl/rgb_sched_pkg.sv - shared types and constants for the RGB channel scheduler
package rgb_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE_R = 2'd1,
    ISSUE_G = 2'd2,
    ISSUE_B = 2'd3
  } sched_state_e;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  localparam int DEFAULT_MAX_OUTSTANDING = 16;

  // Outstanding counter must hold the value MAX_OUTSTANDING itself
  function automatic int out_cnt_width(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

  localparam int DEFAULT_OUT_CNT_W = out_cnt_width(DEFAULT_MAX_OUTSTANDING);

endpackage

// File: rtl/rgb_channel_scheduler_if.sv
// rtl/rgb_channel_scheduler_if.sv - pixel, core and result signals of the RGB channel scheduler
interface rgb_channel_scheduler_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] r_in;
  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] b_in;

  logic             flt_valid;
  logic [1:0]       flt_tag;
  logic [WIDTH-1:0] flt_data;

  logic             flt_ret_valid;
  logic [1:0]       flt_ret_tag;
  logic [WIDTH-1:0] flt_ret_data;

  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] g_data_out;
  logic [WIDTH-1:0] b_data_out;
  logic             data_out_done;
  logic             busy;
  logic             err_tag;
  logic             err_underflow;

  modport master (
    input  in_valid, r_in, g_in, b_in,
    input  flt_ret_valid, flt_ret_tag, flt_ret_data,
    output in_ready, flt_valid, flt_tag, flt_data,
    output r_data_out, g_data_out, b_data_out, data_out_done,
    output busy, err_tag, err_underflow
  );

  modport slave (
    output in_valid, r_in, g_in, b_in,
    output flt_ret_valid, flt_ret_tag, flt_ret_data,
    input  in_ready, flt_valid, flt_tag, flt_data,
    input  r_data_out, g_data_out, b_data_out, data_out_done,
    input  busy, err_tag, err_underflow
  );

endinterface

// File: rtl/rgb_sched_collect.sv
// rtl/rgb_sched_collect.sv - reassembles in-order core results into aligned RGB triples
module rgb_sched_collect
  import rgb_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ret_valid,
  input  logic [1:0]       ret_tag,
  input  logic [WIDTH-1:0] ret_data,
  output logic [WIDTH-1:0] r_out,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] b_out,
  output logic             done,
  output logic             err_tag
);

  logic [1:0]       phase_q, phase_d;
  logic [WIDTH-1:0] r_stage_q, r_stage_d;
  logic [WIDTH-1:0] g_stage_q, g_stage_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic [WIDTH-1:0] g_out_q, g_out_d;
  logic [WIDTH-1:0] b_out_q, b_out_d;
  logic             done_q, done_d;
  logic             err_tag_q, err_tag_d;

  // Phase follows return order only; a wrong tag is flagged but data still lands by position
  always_comb begin
    phase_d   = phase_q;
    r_stage_d = r_stage_q;
    g_stage_d = g_stage_q;
    r_out_d   = r_out_q;
    g_out_d   = g_out_q;
    b_out_d   = b_out_q;
    done_d    = 1'b0;
    err_tag_d = err_tag_q;
    if (ret_valid) begin
      if (ret_tag != phase_q) begin
        err_tag_d = 1'b1;
      end
      case (phase_q)
        CH_R: begin
          r_stage_d = ret_data;
          phase_d   = CH_G;
        end
        CH_G: begin
          g_stage_d = ret_data;
          phase_d   = CH_B;
        end
        default: begin
          r_out_d = r_stage_q;
          g_out_d = g_stage_q;
          b_out_d = ret_data;
          done_d  = 1'b1;
          phase_d = CH_R;
        end
      endcase
    end
  end

  // Collector state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= CH_R;
      r_stage_q <= '0;
      g_stage_q <= '0;
      r_out_q   <= '0;
      g_out_q   <= '0;
      b_out_q   <= '0;
      done_q    <= 1'b0;
      err_tag_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      r_stage_q <= r_stage_d;
      g_stage_q <= g_stage_d;
      r_out_q   <= r_out_d;
      g_out_q   <= g_out_d;
      b_out_q   <= b_out_d;
      done_q    <= done_d;
      err_tag_q <= err_tag_d;
    end
  end

  assign r_out   = r_out_q;
  assign g_out   = g_out_q;
  assign b_out   = b_out_q;
  assign done    = done_q;
  assign err_tag = err_tag_q;

endmodule

// File: rtl/rgb_channel_scheduler.sv
// rtl/rgb_channel_scheduler.sv - time-multiplexes one sharpening core across R, G and B
module rgb_channel_scheduler
  import rgb_sched_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
  input logic                     clk,
  input logic                     reset,
  rgb_channel_scheduler_if.master bus
);

  localparam int             CNT_W   = out_cnt_width(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  sched_state_e     state_q, state_d;
  logic [WIDTH-1:0] r_hold_q, r_hold_d;
  logic [WIDTH-1:0] g_hold_q, g_hold_d;
  logic [WIDTH-1:0] b_hold_q, b_hold_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             underflow_q, underflow_d;

  logic             can_issue;
  logic             in_ready;
  logic             accept;
  logic             flt_valid;
  logic [1:0]       flt_tag;
  logic [WIDTH-1:0] flt_data;

  // State, hold, outstanding count and underflow flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      r_hold_q    <= '0;
      g_hold_q    <= '0;
      b_hold_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_hold_q    <= r_hold_d;
      g_hold_q    <= g_hold_d;
      b_hold_q    <= b_hold_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  // Next state: advance only when the current beat issues; B issue may chain straight into a new pixel
  always_comb begin
    state_d     = state_q;
    r_hold_d    = r_hold_q;
    g_hold_d    = g_hold_q;
    b_hold_d    = b_hold_q;
    count_d     = count_q;
    underflow_d = underflow_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE_R;
      ISSUE_R: if (flt_valid) state_d = ISSUE_G;
      ISSUE_G: if (flt_valid) state_d = ISSUE_B;
      ISSUE_B: if (flt_valid) state_d = accept ? ISSUE_R : IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      r_hold_d = bus.r_in;
      g_hold_d = bus.g_in;
      b_hold_d = bus.b_in;
    end
    if (flt_valid && !bus.flt_ret_valid) begin
      count_d = count_q + CNT_W'(1);
    end else if (!flt_valid && bus.flt_ret_valid && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
    if (bus.flt_ret_valid && (count_q == '0)) begin
      underflow_d = 1'b1;
    end
  end

  // Outputs: issue is throttled by the outstanding count; in_ready is forced low during reset
  always_comb begin
    can_issue = (count_q < MAX_CNT);
    in_ready  = 1'b0;
    flt_valid = 1'b0;
    flt_tag   = CH_R;
    flt_data  = '0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      ISSUE_R: if (can_issue) begin
        flt_valid = 1'b1;
        flt_tag   = CH_R;
        flt_data  = r_hold_q;
      end
      ISSUE_G: if (can_issue) begin
        flt_valid = 1'b1;
        flt_tag   = CH_G;
        flt_data  = g_hold_q;
      end
      ISSUE_B: if (can_issue) begin
        flt_valid = 1'b1;
        flt_tag   = CH_B;
        flt_data  = b_hold_q;
        in_ready  = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
    if (reset) begin
      in_ready = 1'b0;
    end
    accept = in_ready && bus.in_valid;
  end

  assign bus.in_ready      = in_ready;
  assign bus.flt_valid     = flt_valid;
  assign bus.flt_tag       = flt_tag;
  assign bus.flt_data      = flt_data;
  assign bus.busy          = (state_q != IDLE) || (count_q != '0);
  assign bus.err_underflow = underflow_q;

  rgb_sched_collect #(
    .WIDTH(WIDTH)
  ) u_collect (
    .clk      (clk),
    .reset    (reset),
    .ret_valid(bus.flt_ret_valid),
    .ret_tag  (bus.flt_ret_tag),
    .ret_data (bus.flt_ret_data),
    .r_out    (bus.r_data_out),
    .g_out    (bus.g_data_out),
    .b_out    (bus.b_data_out),
    .done     (bus.data_out_done),
    .err_tag  (bus.err_tag)
  );

endmodule

// File: tb/tb_rgb_channel_scheduler.sv
// tb/tb_rgb_channel_scheduler.sv - self-checking bench for rgb_channel_scheduler
module tb_rgb_channel_scheduler;

  localparam int LAT_A = 4;
  localparam int LAT_B = 6;
  localparam int N_B   = 24;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic spur_a = 1'b0;
  logic swap_a = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // Free-running cycle number for timing comparisons
  always @(posedge clk) cyc <= cyc + 1;

  rgb_channel_scheduler_if #(.WIDTH(8)) bus_a ();
  rgb_channel_scheduler_if #(.WIDTH(8)) bus_b ();

  rgb_channel_scheduler #(.WIDTH(8), .MAX_OUTSTANDING(16)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a)
  );
  rgb_channel_scheduler #(.WIDTH(8), .MAX_OUTSTANDING(2)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b)
  );

  // Stub cores: fixed latency, add 1, optional G/B tag swap on core A
  logic       pa_v [LAT_A];
  logic [1:0] pa_t [LAT_A];
  logic [7:0] pa_d [LAT_A];
  logic       pb_v [LAT_B];
  logic [1:0] pb_t [LAT_B];
  logic [7:0] pb_d [LAT_B];

  always @(posedge clk) begin
    if (rst_a) begin
      for (int i = 0; i < LAT_A; i++) begin pa_v[i] <= 1'b0; pa_t[i] <= 2'd0; pa_d[i] <= 8'd0; end
    end else begin
      pa_v[0] <= bus_a.flt_valid; pa_t[0] <= bus_a.flt_tag; pa_d[0] <= bus_a.flt_data + 8'd1;
      for (int i = 1; i < LAT_A; i++) begin pa_v[i] <= pa_v[i-1]; pa_t[i] <= pa_t[i-1]; pa_d[i] <= pa_d[i-1]; end
    end
  end

  always @(posedge clk) begin
    if (rst_b) begin
      for (int i = 0; i < LAT_B; i++) begin pb_v[i] <= 1'b0; pb_t[i] <= 2'd0; pb_d[i] <= 8'd0; end
    end else begin
      pb_v[0] <= bus_b.flt_valid; pb_t[0] <= bus_b.flt_tag; pb_d[0] <= bus_b.flt_data + 8'd1;
      for (int i = 1; i < LAT_B; i++) begin pb_v[i] <= pb_v[i-1]; pb_t[i] <= pb_t[i-1]; pb_d[i] <= pb_d[i-1]; end
    end
  end

  logic [1:0] ta;
  assign ta = pa_t[LAT_A-1];
  assign bus_a.flt_ret_valid = pa_v[LAT_A-1] | spur_a;
  assign bus_a.flt_ret_tag   = spur_a ? 2'd0 : (swap_a && ta == 2'd1) ? 2'd2 : (swap_a && ta == 2'd2) ? 2'd1 : ta;
  assign bus_a.flt_ret_data  = pa_d[LAT_A-1];
  assign bus_b.flt_ret_valid = pb_v[LAT_B-1];
  assign bus_b.flt_ret_tag   = pb_t[LAT_B-1];
  assign bus_b.flt_ret_data  = pb_d[LAT_B-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] chan(input logic [23:0] p, input int ch);
    return (ch == 0) ? p[23:16] : (ch == 1) ? p[15:8] : p[7:0];
  endfunction

  // Single pixel on core A from IDLE, checking per-cycle issue and done timing
  task automatic run_single(input string nm, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    @(posedge clk); #1;
    bus_a.in_valid = 1'b1; bus_a.r_in = r; bus_a.g_in = g; bus_a.b_in = b;
    @(negedge clk);
    check({nm, "_t0_ready"}, bus_a.in_ready, 1);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      bus_a.in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("%s_fv%0d", nm, k), bus_a.flt_valid, (k <= 3) ? 1 : 0);
      if (k <= 3) begin
        check($sformatf("%s_tag%0d", nm, k), bus_a.flt_tag, k - 1);
        check($sformatf("%s_data%0d", nm, k), bus_a.flt_data, (k == 1) ? r : (k == 2) ? g : b);
      end
      check($sformatf("%s_done%0d", nm, k), bus_a.data_out_done, (k == 8) ? 1 : 0);
      if (k == 6) check({nm, "_err_tag_pre"}, bus_a.err_tag, 0);
      if (k == 7) check({nm, "_err_tag_post"}, bus_a.err_tag, swap_a ? 1 : 0);
      if (k == 8) begin
        check({nm, "_r"}, bus_a.r_data_out, 8'(r + 8'd1));
        check({nm, "_g"}, bus_a.g_data_out, 8'(g + 8'd1));
        check({nm, "_b"}, bus_a.b_data_out, 8'(b + 8'd1));
      end
      if (k == 4) check({nm, "_busy_mid"}, bus_a.busy, 1);
      if (k == 9) check({nm, "_busy_end"}, bus_a.busy, 0);
    end
  endtask

  logic [7:0]  pr [4];
  logic [7:0]  pg [4];
  logic [7:0]  pb [4];
  int          acc_c [4];
  int          dn_c [4];
  logic [23:0] acc_pix [64];

  initial begin
    int ai, di, acc_n, iss_n, done_n, inflight, stall_seen;
    bit acc_flag;
    logic [23:0] p;
    bus_a.in_valid = 1'b0; bus_a.r_in = 8'd0; bus_a.g_in = 8'd0; bus_a.b_in = 8'd0;
    bus_b.in_valid = 1'b0; bus_b.r_in = 8'd0; bus_b.g_in = 8'd0; bus_b.b_in = 8'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus_a.in_ready, 0);
    check("rst_done", bus_a.data_out_done, 0);
    check("rst_busy", bus_a.busy, 0);
    check("rst_r_out", bus_a.r_data_out, 0);
    check("rst_err", {bus_a.err_tag, bus_a.err_underflow}, 0);
    @(posedge clk); #1;
    rst_a = 1'b0;

    run_single("p1", 8'd10, 8'd20, 8'd30);

    // Back-to-back pixels on core A
    for (int i = 0; i < 4; i++) begin
      pr[i] = 8'($urandom); pg[i] = 8'($urandom); pb[i] = 8'($urandom);
      acc_c[i] = 0; dn_c[i] = 0;
    end
    ai = 0; di = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      bus_a.in_valid = (ai < 4);
      if (ai < 4) begin bus_a.r_in = pr[ai]; bus_a.g_in = pg[ai]; bus_a.b_in = pb[ai]; end
      @(negedge clk);
      if (bus_a.data_out_done) begin
        if (di < 4) begin
          dn_c[di] = cyc;
          check($sformatf("b2b_r%0d", di), bus_a.r_data_out, 8'(pr[di] + 8'd1));
          check($sformatf("b2b_g%0d", di), bus_a.g_data_out, 8'(pg[di] + 8'd1));
          check($sformatf("b2b_b%0d", di), bus_a.b_data_out, 8'(pb[di] + 8'd1));
          di++;
        end else begin
          check("b2b_extra_done", bus_a.data_out_done, 0);
        end
      end
      if (bus_a.in_valid && bus_a.in_ready) begin
        acc_c[ai] = cyc;
        ai++;
      end
    end
    check("b2b_acc_n", ai, 4);
    check("b2b_done_n", di, 4);
    for (int i = 1; i < 4; i++) check($sformatf("b2b_acc_gap%0d", i), acc_c[i] - acc_c[0], 3 * i);
    for (int i = 0; i < 4; i++) check($sformatf("b2b_done_at%0d", i), dn_c[i] - acc_c[0], 8 + 3 * i);

    // Tag mismatch: core returns tags 0,2,1
    swap_a = 1'b1;
    run_single("swp", 8'd5, 8'd6, 8'd7);
    swap_a = 1'b0;

    // Reset in the middle of a pixel
    @(posedge clk); #1;
    bus_a.in_valid = 1'b1; bus_a.r_in = 8'd40; bus_a.g_in = 8'd50; bus_a.b_in = 8'd60;
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b1;
    @(negedge clk);
    check("mr_ready_in_rst", bus_a.in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mr_fv", bus_a.flt_valid, 0);
    check("mr_done", bus_a.data_out_done, 0);
    check("mr_rgb", {bus_a.r_data_out, bus_a.g_data_out, bus_a.b_data_out}, 0);
    check("mr_err_tag", bus_a.err_tag, 0);
    check("mr_err_uf", bus_a.err_underflow, 0);
    check("mr_busy", bus_a.busy, 0);
    check("mr_ready", bus_a.in_ready, 0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    run_single("mr2", 8'd70, 8'd80, 8'd90);

    // Spurious return while idle
    @(posedge clk); #1;
    spur_a = 1'b1;
    @(negedge clk);
    check("spur_uf_pre", bus_a.err_underflow, 0);
    @(posedge clk); #1;
    spur_a = 1'b0;
    @(negedge clk);
    check("spur_uf", bus_a.err_underflow, 1);
    check("spur_busy", bus_a.busy, 0);
    check("spur_err_tag", bus_a.err_tag, 0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("spur_done%0d", k), bus_a.data_out_done, 0);
      @(negedge clk);
    end

    // Throttled core B: random pixels, scoreboard on issue order and results
    acc_n = 0; iss_n = 0; done_n = 0; inflight = 0; stall_seen = 0; acc_flag = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b0;
    for (int c = 0; c < 2000 && done_n < N_B; c++) begin
      @(posedge clk); #1;
      if (acc_flag) begin bus_b.in_valid = 1'b0; acc_flag = 1'b0; end
      if (!bus_b.in_valid && acc_n < N_B && $urandom_range(0, 3) != 0) begin
        bus_b.r_in = 8'($urandom); bus_b.g_in = 8'($urandom); bus_b.b_in = 8'($urandom);
        bus_b.in_valid = 1'b1;
      end
      @(negedge clk);
      if (bus_b.in_valid && bus_b.in_ready) begin
        acc_pix[acc_n] = {bus_b.r_in, bus_b.g_in, bus_b.b_in};
        acc_n++;
        acc_flag = 1'b1;
      end
      if (bus_b.flt_valid) begin
        check("thr_inflight", inflight < 2, 1);
        p = acc_pix[iss_n / 3];
        check("thr_tag", bus_b.flt_tag, iss_n % 3);
        check("thr_data", bus_b.flt_data, chan(p, iss_n % 3));
        iss_n++;
      end else if (inflight == 2 && iss_n < 3 * acc_n) begin
        stall_seen++;
      end
      if (bus_b.data_out_done) begin
        p = acc_pix[done_n];
        check("thr_rgb", {bus_b.r_data_out, bus_b.g_data_out, bus_b.b_data_out},
              {8'(p[23:16] + 8'd1), 8'(p[15:8] + 8'd1), 8'(p[7:0] + 8'd1)});
        done_n++;
      end
      inflight = inflight + (bus_b.flt_valid ? 1 : 0) - (bus_b.flt_ret_valid ? 1 : 0);
    end
    check("thr_acc_n", acc_n, N_B);
    check("thr_done_n", done_n, N_B);
    check("thr_stall_seen", stall_seen != 0, 1);
    @(negedge clk);
    check("thr_busy_end", bus_b.busy, 0);
    check("thr_err", {bus_b.err_tag, bus_b.err_underflow}, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
